// File: rtl/commit_trace_buffer.sv
// Commit/memory/event trace FIFO between the core-interface shim and the spec checker.
// Records are tagged with a wrapping sequence number; records lost to overflow are counted.
module commit_trace_buffer #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 64,
    parameter int SEQW  = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       instCommit_valid,
    input  logic [31:0]                instCommit_inst,
    input  logic [XLEN-1:0]            instCommit_pc,
    input  logic                       mem_read_valid,
    input  logic [XLEN-1:0]            mem_read_addr,
    input  logic [2:0]                 mem_read_memWidth,
    input  logic                       mem_write_valid,
    input  logic [XLEN-1:0]            mem_write_addr,
    input  logic [XLEN-1:0]            mem_write_data,
    input  logic [2:0]                 mem_write_memWidth,
    input  logic                       event_valid,
    input  logic [XLEN-1:0]            event_intrNO,
    input  logic [XLEN-1:0]            event_cause,
    input  logic [XLEN-1:0]            event_exceptionPC,
    input  logic [31:0]                event_exceptionInst,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [SEQW-1:0]            out_seq,
    output logic                       out_instCommit_valid,
    output logic [31:0]                out_instCommit_inst,
    output logic [XLEN-1:0]            out_instCommit_pc,
    output logic                       out_mem_read_valid,
    output logic [XLEN-1:0]            out_mem_read_addr,
    output logic [2:0]                 out_mem_read_memWidth,
    output logic                       out_mem_write_valid,
    output logic [XLEN-1:0]            out_mem_write_addr,
    output logic [XLEN-1:0]            out_mem_write_data,
    output logic [2:0]                 out_mem_write_memWidth,
    output logic                       out_event_valid,
    output logic [XLEN-1:0]            out_event_intrNO,
    output logic [XLEN-1:0]            out_event_cause,
    output logic [XLEN-1:0]            out_event_exceptionPC,
    output logic [31:0]                out_event_exceptionInst,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [15:0]                drop_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [SEQW-1:0] seq;
        logic            c_valid;
        logic [31:0]     c_inst;
        logic [XLEN-1:0] c_pc;
        logic            r_valid;
        logic [XLEN-1:0] r_addr;
        logic [2:0]      r_width;
        logic            w_valid;
        logic [XLEN-1:0] w_addr;
        logic [XLEN-1:0] w_data;
        logic [2:0]      w_width;
        logic            e_valid;
        logic [XLEN-1:0] e_intr;
        logic [XLEN-1:0] e_cause;
        logic [XLEN-1:0] e_pc;
        logic [31:0]     e_inst;
    } rec_t;

    rec_t            mem [DEPTH];
    rec_t            in_rec;
    rec_t            head;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count_q;
    logic [SEQW-1:0] seq_next;
    logic            full;
    logic            empty;
    logic            capture;
    logic            pop;
    logic            push;
    logic            drop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign capture = instCommit_valid | event_valid;
    assign pop     = !empty & out_ready;
    assign push    = capture & (!full | pop);
    assign drop    = capture & full & !pop;

    always_comb begin
        in_rec         = '0;
        in_rec.seq     = seq_next;
        in_rec.c_valid = instCommit_valid;
        in_rec.c_inst  = instCommit_inst;
        in_rec.c_pc    = instCommit_pc;
        in_rec.r_valid = mem_read_valid;
        in_rec.r_addr  = mem_read_addr;
        in_rec.r_width = mem_read_memWidth;
        in_rec.w_valid = mem_write_valid;
        in_rec.w_addr  = mem_write_addr;
        in_rec.w_data  = mem_write_data;
        in_rec.w_width = mem_write_memWidth;
        in_rec.e_valid = event_valid;
        in_rec.e_intr  = event_intrNO;
        in_rec.e_cause = event_cause;
        in_rec.e_pc    = event_exceptionPC;
        in_rec.e_inst  = event_exceptionInst;
    end

    // Storage is deliberately not reset; only the pointers and occupancy are.
    always_ff @(posedge clock) begin
        if (push && !reset)
            mem[wr_ptr] <= in_rec;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count_q  <= '0;
            seq_next <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + 1'b1;
                seq_next <= seq_next + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count_q <= count_q + 1'b1;
            else if (pop && !push)
                count_q <= count_q - 1'b1;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != '1)
                    drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    assign head  = mem[rd_ptr];
    assign count = count_q;

    assign out_valid               = !empty;
    assign out_seq                 = head.seq;
    assign out_instCommit_valid    = head.c_valid;
    assign out_instCommit_inst     = head.c_inst;
    assign out_instCommit_pc       = head.c_pc;
    assign out_mem_read_valid      = head.r_valid;
    assign out_mem_read_addr       = head.r_addr;
    assign out_mem_read_memWidth   = head.r_width;
    assign out_mem_write_valid     = head.w_valid;
    assign out_mem_write_addr      = head.w_addr;
    assign out_mem_write_data      = head.w_data;
    assign out_mem_write_memWidth  = head.w_width;
    assign out_event_valid         = head.e_valid;
    assign out_event_intrNO        = head.e_intr;
    assign out_event_cause         = head.e_cause;
    assign out_event_exceptionPC   = head.e_pc;
    assign out_event_exceptionInst = head.e_inst;
endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer with SEQW=4 so sequence wrap is reachable.
module tb_commit_trace_buffer;
    logic        clock = 1'b0;
    logic        reset;
    logic        instCommit_valid;
    logic [31:0] instCommit_inst;
    logic [63:0] instCommit_pc;
    logic        mem_read_valid;
    logic [63:0] mem_read_addr;
    logic [2:0]  mem_read_memWidth;
    logic        mem_write_valid;
    logic [63:0] mem_write_addr;
    logic [63:0] mem_write_data;
    logic [2:0]  mem_write_memWidth;
    logic        event_valid;
    logic [63:0] event_intrNO;
    logic [63:0] event_cause;
    logic [63:0] event_exceptionPC;
    logic [31:0] event_exceptionInst;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_seq;
    logic        out_instCommit_valid;
    logic [31:0] out_instCommit_inst;
    logic [63:0] out_instCommit_pc;
    logic        out_mem_read_valid;
    logic [63:0] out_mem_read_addr;
    logic [2:0]  out_mem_read_memWidth;
    logic        out_mem_write_valid;
    logic [63:0] out_mem_write_addr;
    logic [63:0] out_mem_write_data;
    logic [2:0]  out_mem_write_memWidth;
    logic        out_event_valid;
    logic [63:0] out_event_intrNO;
    logic [63:0] out_event_cause;
    logic [63:0] out_event_exceptionPC;
    logic [31:0] out_event_exceptionInst;
    logic [3:0]  count;
    logic        overflow;
    logic [15:0] drop_cnt;

    int checks = 0;
    int failures = 0;

    commit_trace_buffer #(.DEPTH(8), .XLEN(64), .SEQW(4)) dut (
        .clock(clock), .reset(reset),
        .instCommit_valid(instCommit_valid), .instCommit_inst(instCommit_inst),
        .instCommit_pc(instCommit_pc),
        .mem_read_valid(mem_read_valid), .mem_read_addr(mem_read_addr),
        .mem_read_memWidth(mem_read_memWidth),
        .mem_write_valid(mem_write_valid), .mem_write_addr(mem_write_addr),
        .mem_write_data(mem_write_data), .mem_write_memWidth(mem_write_memWidth),
        .event_valid(event_valid), .event_intrNO(event_intrNO), .event_cause(event_cause),
        .event_exceptionPC(event_exceptionPC), .event_exceptionInst(event_exceptionInst),
        .out_valid(out_valid), .out_ready(out_ready), .out_seq(out_seq),
        .out_instCommit_valid(out_instCommit_valid), .out_instCommit_inst(out_instCommit_inst),
        .out_instCommit_pc(out_instCommit_pc),
        .out_mem_read_valid(out_mem_read_valid), .out_mem_read_addr(out_mem_read_addr),
        .out_mem_read_memWidth(out_mem_read_memWidth),
        .out_mem_write_valid(out_mem_write_valid), .out_mem_write_addr(out_mem_write_addr),
        .out_mem_write_data(out_mem_write_data), .out_mem_write_memWidth(out_mem_write_memWidth),
        .out_event_valid(out_event_valid), .out_event_intrNO(out_event_intrNO),
        .out_event_cause(out_event_cause), .out_event_exceptionPC(out_event_exceptionPC),
        .out_event_exceptionInst(out_event_exceptionInst),
        .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        instCommit_valid = 1'b0; instCommit_inst = '0; instCommit_pc = '0;
        mem_read_valid = 1'b0; mem_read_addr = '0; mem_read_memWidth = '0;
        mem_write_valid = 1'b0; mem_write_addr = '0; mem_write_data = '0;
        mem_write_memWidth = '0;
        event_valid = 1'b0; event_intrNO = '0; event_cause = '0;
        event_exceptionPC = '0; event_exceptionInst = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic commit(input logic [63:0] pc);
        instCommit_valid = 1'b1;
        instCommit_inst  = 32'h00000013;
        instCommit_pc    = pc;
        step();
        instCommit_valid = 1'b0;
    endtask

    initial begin
        idle_inputs();
        out_ready = 1'b0;
        do_reset();
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);

        // 1: first capture visible one cycle later
        commit(64'h80000000);
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_seq", 64'(out_seq), 64'd0);
        chk("t1_pc", out_instCommit_pc, 64'h80000000);
        chk("t1_inst", 64'(out_instCommit_inst), 64'h13);
        chk("t1_count", 64'(count), 64'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t1_drained", 64'(count), 64'd0);
        chk("t1_valid_low", 64'(out_valid), 64'd0);

        // 2: fill, then overflow one record
        do_reset();
        for (int i = 0; i < 8; i++) commit(64'h1000 + 64'(i * 4));
        chk("t2_count_full", 64'(count), 64'd8);
        chk("t2_no_ovf", 64'(overflow), 64'd0);
        commit(64'h1020);
        chk("t2_overflow", 64'(overflow), 64'd1);
        chk("t2_drop_cnt", 64'(drop_cnt), 64'd1);
        chk("t2_count_after_drop", 64'(count), 64'd8);
        chk("t2_head_seq", 64'(out_seq), 64'd0);
        chk("t2_head_pc", out_instCommit_pc, 64'h1000);

        // 3: push+pop while full
        out_ready = 1'b1;
        commit(64'h2000);
        chk("t3_count", 64'(count), 64'd8);
        chk("t3_drop_cnt", 64'(drop_cnt), 64'd1);
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("t3_seq%0d", i), 64'(out_seq), 64'(i));
            chk($sformatf("t3_pc%0d", i), out_instCommit_pc,
                (i < 8) ? 64'h1000 + 64'(i * 4) : 64'h2000);
            step();
        end
        out_ready = 1'b0;
        chk("t3_empty", 64'(count), 64'd0);
        chk("t3_overflow_sticky", 64'(overflow), 64'd1);

        // 4: event-only record
        event_valid = 1'b1; event_cause = 64'h2; event_exceptionPC = 64'h80000010;
        event_intrNO = 64'h5; event_exceptionInst = 32'h00100073;
        step();
        idle_inputs();
        chk("t4_count", 64'(count), 64'd1);
        chk("t4_ev_valid", 64'(out_event_valid), 64'd1);
        chk("t4_commit_valid", 64'(out_instCommit_valid), 64'd0);
        chk("t4_cause", out_event_cause, 64'h2);
        chk("t4_epc", out_event_exceptionPC, 64'h80000010);
        chk("t4_intr", out_event_intrNO, 64'h5);
        chk("t4_einst", 64'(out_event_exceptionInst), 64'h00100073);
        chk("t4_seq", 64'(out_seq), 64'd9);
        out_ready = 1'b1; step(); out_ready = 1'b0;

        // 5: memory write alone is ignored, with a commit it is stored
        mem_write_valid = 1'b1; mem_write_addr = 64'h3000;
        mem_write_data = 64'hDEADBEEF_CAFEF00D; mem_write_memWidth = 3'd3;
        step();
        chk("t5_no_push", 64'(count), 64'd0);
        chk("t5_no_valid", 64'(out_valid), 64'd0);
        commit(64'h80000020);
        idle_inputs();
        chk("t5_count", 64'(count), 64'd1);
        chk("t5_w_valid", 64'(out_mem_write_valid), 64'd1);
        chk("t5_w_addr", out_mem_write_addr, 64'h3000);
        chk("t5_w_data", out_mem_write_data, 64'hDEADBEEF_CAFEF00D);
        chk("t5_w_width", 64'(out_mem_write_memWidth), 64'd3);
        chk("t5_r_valid", 64'(out_mem_read_valid), 64'd0);
        chk("t5_seq", 64'(out_seq), 64'd10);
        out_ready = 1'b1; step(); out_ready = 1'b0;

        // 6: sequence wrap 15 -> 0, then reset with records queued
        for (int i = 0; i < 5; i++) commit(64'h4000 + 64'(i));
        chk("t6_head_seq", 64'(out_seq), 64'd11);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        out_ready = 1'b0;
        chk("t6_drained", 64'(count), 64'd0);
        commit(64'h5000);
        chk("t6_wrap_seq", 64'(out_seq), 64'd0);
        commit(64'h5004);
        commit(64'h5008);
        chk("t6_queued", 64'(count), 64'd3);
        reset = 1'b1;
        instCommit_valid = 1'b1; instCommit_pc = 64'h6000;
        step();
        reset = 1'b0;
        instCommit_valid = 1'b0;
        chk("t6_rst_valid", 64'(out_valid), 64'd0);
        chk("t6_rst_count", 64'(count), 64'd0);
        chk("t6_rst_overflow", 64'(overflow), 64'd0);
        chk("t6_rst_drop", 64'(drop_cnt), 64'd0);
        commit(64'h7000);
        chk("t6_post_seq", 64'(out_seq), 64'd0);
        chk("t6_post_pc", out_instCommit_pc, 64'h7000);
        chk("t6_post_count", 64'(count), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
